// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and helpers for the stopwatch controller: FSM encoding and BCD count.
// Purely declarative; no latency.
// No flow control.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2,
        S_LAP  = 2'd3
    } state_t;

    // Largest value a digit may hold before it rolls over and carries.
    localparam logic [3:0] BCD_MAX9 = 4'd9;
    localparam logic [3:0] BCD_MAX5 = 4'd5;

    // MM:SS.cc, most significant digit first so the struct maps straight onto DISP.
    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_u;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
        logic [3:0] cs_t;
        logic [3:0] cs_u;
    } bcd_t;

    // One BCD digit step: returns {carry_out, new_digit}.
    function automatic logic [4:0] dig_inc(input logic [3:0] d, input logic [3:0] maxv,
                                           input logic cin);
        logic [4:0] r;
        if (!cin)
            r = {1'b0, d};
        else if (d == maxv)
            r = {1'b1, 4'd0};
        else
            r = {1'b0, d + 4'd1};
        return r;
    endfunction

    // Advance the count by one centisecond; 59:59.99 wraps to 00:00.00.
    function automatic bcd_t bcd_inc(input bcd_t c);
        bcd_t       n;
        logic [4:0] r;
        r = dig_inc(c.cs_u,  BCD_MAX9, 1'b1); n.cs_u  = r[3:0];
        r = dig_inc(c.cs_t,  BCD_MAX9, r[4]); n.cs_t  = r[3:0];
        r = dig_inc(c.sec_u, BCD_MAX9, r[4]); n.sec_u = r[3:0];
        r = dig_inc(c.sec_t, BCD_MAX5, r[4]); n.sec_t = r[3:0];
        r = dig_inc(c.min_u, BCD_MAX9, r[4]); n.min_u = r[3:0];
        r = dig_inc(c.min_t, BCD_MAX5, r[4]); n.min_t = r[3:0];
        return n;
    endfunction

    // True when the next increment wraps the whole count.
    function automatic logic bcd_at_max(input bcd_t c);
        return (c.min_t == BCD_MAX5) && (c.min_u == BCD_MAX9) &&
               (c.sec_t == BCD_MAX5) && (c.sec_u == BCD_MAX9) &&
               (c.cs_t  == BCD_MAX9) && (c.cs_u  == BCD_MAX9);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button synchroniser + debouncer: 2-FF sync, level flips after DB_SAMPLES agreeing CE samples.
// Latency: 2 CLK sync + DB_SAMPLES CE samples to LEVEL, PRESS one CLK after the rising flip.
// No backpressure; PRESS is a single-cycle pulse that is lost if not consumed.
module btn_debounce #(
    parameter logic [3:0] DB_SAMPLES = 4'd8
) (
    input  logic CLK,
    input  logic RST,
    input  logic CE,
    input  logic BTN_IN,
    output logic LEVEL,
    output logic PRESS
);

    logic       sync1;
    logic       sync2;
    logic       level;
    logic       level_d;
    logic       press;
    logic [3:0] agree_cnt;

    // Bring the asynchronous button into the CLK domain.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= BTN_IN;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing samples; flip the level once enough have been seen.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level     <= 1'b0;
            agree_cnt <= 4'd0;
        end else if (CE) begin
            if (sync2 == level) begin
                agree_cnt <= 4'd0;
            end else if (agree_cnt + 4'd1 == DB_SAMPLES) begin
                level     <= ~level;
                agree_cnt <= 4'd0;
            end else begin
                agree_cnt <= agree_cnt + 4'd1;
            end
        end
    end

    // Rising-edge detect on the debounced level; releases produce nothing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

    assign LEVEL = level;
    assign PRESS = press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// BCD stopwatch (MM:SS.cc) with start/stop, clear and lap-freeze driven by debounced buttons.
// Count/state update on the CLK edge after an event or CE10; DISP is combinational from registers.
// No backpressure; simultaneous button events resolve CLR > SS > LAP and the losers are dropped.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter logic [3:0] DB_SAMPLES = 4'd8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE1,
    input  logic        CE10,
    input  logic        BTN_SS,
    input  logic        BTN_CLR,
    input  logic        BTN_LAP,
    output logic [23:0] DISP,
    output logic        RUNNING,
    output logic        LAP_ACT,
    output logic        OVF
);

    logic   ss_press, clr_press, lap_press;
    logic   ss_level, clr_level, lap_level;
    logic   unused_levels;
    logic   ss_ev, clr_ev, lap_ev;
    state_t state, state_nxt;
    logic   lap_cap, clr_cnt, tick;
    bcd_t   count;
    bcd_t   lap_q;
    logic   ovf;

    btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_ss (
        .CLK(CLK), .RST(RST), .CE(CE1), .BTN_IN(BTN_SS),  .LEVEL(ss_level),  .PRESS(ss_press)
    );
    btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_clr (
        .CLK(CLK), .RST(RST), .CE(CE1), .BTN_IN(BTN_CLR), .LEVEL(clr_level), .PRESS(clr_press)
    );
    btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_lap (
        .CLK(CLK), .RST(RST), .CE(CE1), .BTN_IN(BTN_LAP), .LEVEL(lap_level), .PRESS(lap_press)
    );

    // Debounced levels are not needed here, only the press pulses.
    assign unused_levels = ss_level ^ clr_level ^ lap_level;

    // Only the highest-priority event of a cycle survives.
    assign clr_ev = clr_press;
    assign ss_ev  = ss_press & ~clr_press;
    assign lap_ev = lap_press & ~ss_press & ~clr_press;

    // Counting follows the pre-edge state, so a transition on a CE10 edge does not alter that tick.
    assign tick = CE10 && ((state == S_RUN) || (state == S_LAP));

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode plus the one-shot lap-capture and count-clear strobes.
    always_comb begin
        state_nxt = state;
        lap_cap   = 1'b0;
        clr_cnt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (ss_ev)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                if (ss_ev) begin
                    state_nxt = S_STOP;
                end else if (lap_ev) begin
                    state_nxt = S_LAP;
                    lap_cap   = 1'b1;
                end
            end
            S_LAP: begin
                if (ss_ev)
                    state_nxt = S_STOP;
                else if (lap_ev)
                    state_nxt = S_RUN;
            end
            S_STOP: begin
                if (clr_ev) begin
                    state_nxt = S_IDLE;
                    clr_cnt   = 1'b1;
                end else if (ss_ev) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Live count: cleared from STOP, advanced on each qualifying CE10 tick.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            count <= '0;
        else if (clr_cnt)
            count <= '0;
        else if (tick)
            count <= bcd_inc(count);
    end

    // Overflow pulse lines up with the cycle in which the wrapped count first appears.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            ovf <= 1'b0;
        else
            ovf <= tick && bcd_at_max(count);
    end

    // Lap latch snapshots the pre-edge count when entering LAP.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            lap_q <= '0;
        else if (lap_cap)
            lap_q <= count;
    end

    assign DISP    = (state == S_LAP) ? lap_q : count;
    assign RUNNING = (state == S_RUN) || (state == S_LAP);
    assign LAP_ACT = (state == S_LAP);
    assign OVF     = ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DB_SAMPLES=4 and CE1 every 10 CLK.
// Each tick is ten CE1 periods with CE10 on the last one.
// Expected values are hand-computed BCD constants.
module tb_stopwatch_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CE1, CE10;
    logic        BTN_SS, BTN_CLR, BTN_LAP;
    logic [23:0] DISP;
    logic        RUNNING, LAP_ACT, OVF;

    int checks = 0;
    int errors = 0;
    int press_cnt = 0;
    int ovf_cnt = 0;
    int press_base;
    int ovf_base;

    always #5 CLK = ~CLK;

    stopwatch_ctrl #(.DB_SAMPLES(4'd4)) dut (
        .CLK(CLK), .RST(RST), .CE1(CE1), .CE10(CE10),
        .BTN_SS(BTN_SS), .BTN_CLR(BTN_CLR), .BTN_LAP(BTN_LAP),
        .DISP(DISP), .RUNNING(RUNNING), .LAP_ACT(LAP_ACT), .OVF(OVF)
    );

    // Count start/stop press pulses and OVF-high cycles as flops would see them.
    always @(posedge CLK) begin
        press_cnt <= press_cnt + (dut.ss_press ? 1 : 0);
        ovf_cnt   <= ovf_cnt + (OVF ? 1 : 0);
    end

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One CE1 period: strobe sits mid-period so buttons set at a period boundary are synced.
    task automatic step(input logic c10);
        repeat (5) @(negedge CLK);
        CE1 = 1'b1; CE10 = c10;
        @(negedge CLK);
        CE1 = 1'b0; CE10 = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (9) step(1'b0);
            step(1'b1);
        end
    endtask

    // m = {LAP, CLR, SS}; held 6 periods, then released long enough to settle low.
    task automatic press(input logic [2:0] m);
        {BTN_LAP, BTN_CLR, BTN_SS} = m;
        repeat (6) step(1'b0);
        {BTN_LAP, BTN_CLR, BTN_SS} = 3'b000;
        repeat (5) step(1'b0);
    endtask

    initial begin
        RST = 1'b1; CE1 = 1'b0; CE10 = 1'b0;
        BTN_SS = 1'b0; BTN_CLR = 1'b0; BTN_LAP = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_disp", DISP, 24'h0);
        check("rst_running", {23'd0, RUNNING}, 24'h0);
        check("rst_lap_act", {23'd0, LAP_ACT}, 24'h0);
        check("rst_ovf", {23'd0, OVF}, 24'h0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Bouncing start/stop never agrees for 4 samples: no event.
        press_base = press_cnt;
        for (int i = 0; i < 10; i++) begin
            BTN_SS = (i % 2 == 0);
            step(1'b0);
        end
        BTN_SS = 1'b0;
        repeat (5) step(1'b0);
        check("bounce_running", {23'd0, RUNNING}, 24'h0);
        check("bounce_press", 24'(press_cnt - press_base), 24'd0);

        // Clean press starts the watch; 150 ticks -> 00:01.50.
        press_base = press_cnt;
        press(3'b001);
        check("start_running", {23'd0, RUNNING}, 24'h1);
        check("start_press", 24'(press_cnt - press_base), 24'd1);
        check("start_disp", DISP, 24'h000000);
        ticks(150);
        check("run_150", DISP, 24'h000150);

        // Stop holds the count; clear from STOP zeroes it.
        press(3'b001);
        check("stop_running", {23'd0, RUNNING}, 24'h0);
        check("stop_hold", DISP, 24'h000150);
        press(3'b010);
        check("clr_disp", DISP, 24'h000000);

        // Lap freeze at 00:00.37, live again at 00:00.57.
        press(3'b001);
        ticks(37);
        check("pre_lap", DISP, 24'h000037);
        press(3'b100);
        check("lap_act", {23'd0, LAP_ACT}, 24'h1);
        check("lap_running", {23'd0, RUNNING}, 24'h1);
        ticks(20);
        check("lap_frozen", DISP, 24'h000037);
        press(3'b100);
        check("unlap_act", {23'd0, LAP_ACT}, 24'h0);
        check("unlap_live", DISP, 24'h000057);

        // Clear while running is ignored and counting continues.
        press(3'b010);
        check("clr_run_ignored", DISP, 24'h000057);
        check("clr_run_running", {23'd0, RUNNING}, 24'h1);
        ticks(1);
        check("clr_run_counts", DISP, 24'h000058);

        // From LAP, start/stop goes to STOP with the live count shown.
        press(3'b100);
        ticks(2);
        check("lap2_frozen", DISP, 24'h000058);
        press(3'b001);
        check("lap_stop_running", {23'd0, RUNNING}, 24'h0);
        check("lap_stop_lap_act", {23'd0, LAP_ACT}, 24'h0);
        check("lap_stop_live", DISP, 24'h000060);

        // Resume to 00:02.00, stop, then CLR+SS together: CLR wins -> IDLE, zero.
        press(3'b001);
        ticks(140);
        check("resume_200", DISP, 24'h000200);
        press(3'b001);
        check("stop200_disp", DISP, 24'h000200);
        press(3'b011);
        check("clr_ss_running", {23'd0, RUNNING}, 24'h0);
        check("clr_ss_disp", DISP, 24'h000000);

        // Wrap: preload 59:59.98 while running.
        press(3'b001);
        force dut.count = 24'h595998;
        @(negedge CLK);
        release dut.count;
        ovf_base = ovf_cnt;
        ticks(1);
        check("wrap_595999", DISP, 24'h595999);
        check("wrap_no_ovf_yet", 24'(ovf_cnt - ovf_base), 24'd0);
        ticks(1);
        check("wrap_zero", DISP, 24'h000000);
        check("wrap_ovf_once", 24'(ovf_cnt - ovf_base), 24'd1);
        check("wrap_running", {23'd0, RUNNING}, 24'h1);
        ticks(1);
        check("wrap_continues", DISP, 24'h000001);
        check("wrap_ovf_still_once", 24'(ovf_cnt - ovf_base), 24'd1);

        // Reset while running with start/stop held; the held button re-detects after 4 samples.
        BTN_SS = 1'b1;
        repeat (2) step(1'b0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("midrst_disp", DISP, 24'h0);
        check("midrst_running", {23'd0, RUNNING}, 24'h0);
        check("midrst_lap_act", {23'd0, LAP_ACT}, 24'h0);
        check("midrst_ovf", {23'd0, OVF}, 24'h0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        press_base = press_cnt;
        repeat (3) step(1'b0);
        check("rehold_3_samples", {23'd0, RUNNING}, 24'h0);
        step(1'b0);
        check("rehold_4_samples", {23'd0, RUNNING}, 24'h1);
        BTN_SS = 1'b0;
        repeat (5) step(1'b0);
        check("rehold_one_press", 24'(press_cnt - press_base), 24'd1);
        check("rehold_disp", DISP, 24'h000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
